// File: rtl/exception_ctrl_multi.sv
// ============================================================================
// exception_ctrl_multi : multi-source exception controller with EPC/ERET.
// Rev 1.0
// ============================================================================
`default_nettype none

module exception_ctrl_multi #(
   parameter int                 NUM_SRC    = 3,
   parameter int                 PC_W       = 32,
   parameter int                 CNT_W      = 32,
   parameter int                 EDGE_MODE  = 1,
   parameter logic [PC_W-1:0]    VEC_BASE   = PC_W'(32'h0000_0080),
   parameter logic [PC_W-1:0]    VEC_STRIDE = PC_W'(32'h0000_0010),
   parameter logic [NUM_SRC-1:0] MASK_RST   = '1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_SRC-1:0]       exp_src,
   input  logic [PC_W-1:0]          pc_in,
   input  logic                     cpu_stall,
   input  logic                     eret,
   input  logic                     mask_we,
   input  logic [NUM_SRC-1:0]       mask_wdata,
   output logic                     exc_take,
   output logic [PC_W-1:0]          exc_vector,
   output logic                     ret_take,
   output logic [PC_W-1:0]          epc,
   output logic [3:0]               cause,
   output logic                     in_handler,
   output logic [NUM_SRC-1:0]       pending,
   output logic [NUM_SRC-1:0]       mask,
   output logic [NUM_SRC*CNT_W-1:0] exc_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2,
      ST_RET     = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_SRC-1:0]   src_q, src_d;
   logic [NUM_SRC-1:0]   pending_q, pending_d;
   logic [NUM_SRC-1:0]   mask_q, mask_d;
   logic [PC_W-1:0]      epc_q, epc_d;
   logic [PC_W-1:0]      exc_vector_q, exc_vector_d;
   logic [3:0]           cause_q, cause_d;
   logic                 exc_take_q, exc_take_d;
   logic                 ret_take_q, ret_take_d;
   logic                 in_handler_q, in_handler_d;
   logic [CNT_W-1:0]     cnt_q [NUM_SRC];
   logic [CNT_W-1:0]     cnt_d [NUM_SRC];

   logic [NUM_SRC-1:0]   enabled;
   logic [NUM_SRC-1:0]   set_vec;
   logic [NUM_SRC-1:0]   clr_vec;
   logic [3:0]           sel;
   logic                 take;

   always_comb begin
      enabled = pending_q & mask_q;
      // Walk downwards so the lowest enabled index wins.
      sel = 4'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (enabled[i]) sel = 4'(i);
      end
      take    = (state_q == ST_IDLE) && (|enabled) && !cpu_stall;
      clr_vec = take ? (NUM_SRC'(1) << sel) : '0;
      set_vec = (EDGE_MODE != 0) ? (exp_src & ~src_q) : exp_src;

      src_d        = exp_src;
      pending_d    = (pending_q & ~clr_vec) | set_vec;
      mask_d       = mask_we ? mask_wdata : mask_q;
      epc_d        = take ? pc_in : epc_q;
      cause_d      = take ? sel : cause_q;
      exc_vector_d = take ? (VEC_BASE + PC_W'(sel) * VEC_STRIDE) : exc_vector_q;

      for (int i = 0; i < NUM_SRC; i++) begin
         cnt_d[i] = cnt_q[i];
         if (take && (sel == 4'(i)) && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (take) state_d = ST_REQ;
         ST_REQ:     state_d = ST_SERVICE;
         ST_SERVICE: if (eret) state_d = ST_RET;
         ST_RET:     state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      exc_take_d   = take;
      ret_take_d   = (state_q == ST_SERVICE) && eret;
      in_handler_d = (state_d == ST_SERVICE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         src_q        <= '0;
         pending_q    <= '0;
         mask_q       <= MASK_RST;
         epc_q        <= '0;
         exc_vector_q <= '0;
         cause_q      <= '0;
         exc_take_q   <= 1'b0;
         ret_take_q   <= 1'b0;
         in_handler_q <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         epc_q        <= epc_d;
         exc_vector_q <= exc_vector_d;
         cause_q      <= cause_d;
         exc_take_q   <= exc_take_d;
         ret_take_q   <= ret_take_d;
         in_handler_q <= in_handler_d;
         for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign exc_take   = exc_take_q;
   assign exc_vector = exc_vector_q;
   assign ret_take   = ret_take_q;
   assign epc        = epc_q;
   assign cause      = cause_q;
   assign in_handler = in_handler_q;
   assign pending    = pending_q;
   assign mask       = mask_q;

   generate
      for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
         assign exc_count[g*CNT_W +: CNT_W] = cnt_q[g];
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_exception_ctrl_multi.sv
// ============================================================================
// tb_exception_ctrl_multi : scoreboard bench for exception_ctrl_multi.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exception_ctrl_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  exp_src = 3'b000;
   logic [31:0] pc_in = 32'h0;
   logic        cpu_stall = 1'b0;
   logic        eret = 1'b0;
   logic        mask_we = 1'b0;
   logic [2:0]  mask_wdata = 3'b000;
   logic        exc_take, ret_take, in_handler;
   logic [31:0] exc_vector, epc;
   logic [3:0]  cause;
   logic [2:0]  pending, mask;
   logic [95:0] exc_count;

   logic [2:0]  lvl_src = 3'b000;
   logic        lvl_take, lvl_ret, lvl_inh;
   logic [31:0] lvl_vec, lvl_epc;
   logic [3:0]  lvl_cause;
   logic [2:0]  lvl_pend, lvl_mask;
   logic [95:0] lvl_cnt;

   exception_ctrl_multi u_dut (
      .clk(clk), .rst(rst), .exp_src(exp_src), .pc_in(pc_in), .cpu_stall(cpu_stall),
      .eret(eret), .mask_we(mask_we), .mask_wdata(mask_wdata), .exc_take(exc_take),
      .exc_vector(exc_vector), .ret_take(ret_take), .epc(epc), .cause(cause),
      .in_handler(in_handler), .pending(pending), .mask(mask), .exc_count(exc_count)
   );

   exception_ctrl_multi #(.EDGE_MODE(0)) u_lvl (
      .clk(clk), .rst(rst), .exp_src(lvl_src), .pc_in(32'h0000_0300), .cpu_stall(1'b0),
      .eret(1'b0), .mask_we(1'b0), .mask_wdata(3'b000), .exc_take(lvl_take),
      .exc_vector(lvl_vec), .ret_take(lvl_ret), .epc(lvl_epc), .cause(lvl_cause),
      .in_handler(lvl_inh), .pending(lvl_pend), .mask(lvl_mask), .exc_count(lvl_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] vec;
      logic [31:0] epc;
      logic [3:0]  cause;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] ret_q [$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          take_cnt = 0;
   logic        prev_take = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Scoreboard: every exc_take / ret_take pulse pops one expected entry.
   always @(negedge clk) begin
      if (rst && exc_take) begin
         exp_t e;
         take_cnt++;
         check("take_pulse_width", {63'd0, prev_take}, 64'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_take", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("sb_vector", {32'd0, exc_vector}, {32'd0, e.vec});
            check("sb_epc", {32'd0, epc}, {32'd0, e.epc});
            check("sb_cause", {60'd0, cause}, {60'd0, e.cause});
         end
      end
      if (rst && ret_take) begin
         if (ret_q.size() == 0) check("unexpected_ret", 64'd1, 64'd0);
         else check("sb_ret_epc", {32'd0, epc}, {32'd0, ret_q.pop_front()});
      end
      prev_take <= exc_take;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] v, input logic [31:0] e, input logic [3:0] c);
      exp_t x;
      x.vec = v; x.epc = e; x.cause = c;
      exp_q.push_back(x);
   endtask

   task automatic wait_take(input int max);
      int n = 0;
      while (!exc_take && n < max) begin
         tick();
         n++;
      end
      check("wait_take", {63'd0, exc_take}, 64'd1);
   endtask

   task automatic do_eret(input logic [31:0] e);
      ret_q.push_back(e);
      eret = 1'b1;
      tick();
      eret = 1'b0;
      check("ret_take", {63'd0, ret_take}, 64'd1);
      tick();
   endtask

   initial begin
      int base;

      // Reset held with all sources high.
      exp_src = 3'b111;
      tick(); tick();
      check("rst_take", {63'd0, exc_take}, 64'd0);
      check("rst_pending", {61'd0, pending}, 64'd0);
      check("rst_mask", {61'd0, mask}, 64'd7);
      check("rst_epc", {32'd0, epc}, 64'd0);
      check("rst_inh", {63'd0, in_handler}, 64'd0);
      check("rst_cnt", exc_count[63:0], 64'd0);
      rst = 1'b1;
      tick();
      check("rel_pending", {61'd0, pending}, 64'd7);
      exp_src = 3'b000;
      push_exp(32'h80, 32'h0, 4'd0);
      push_exp(32'h90, 32'h0, 4'd1);
      push_exp(32'hA0, 32'h0, 4'd2);
      for (int i = 0; i < 3; i++) begin
         wait_take(4);
         tick();
         do_eret(32'h0);
      end

      // Single source, latency.
      pc_in = 32'h40;
      push_exp(32'h90, 32'h40, 4'd1);
      exp_src = 3'b010;
      tick();
      check("t2_pending", {61'd0, pending}, 64'd2);
      exp_src = 3'b000;
      check("t2_no_early_take", {63'd0, exc_take}, 64'd0);
      tick();
      check("t2_latency", {63'd0, exc_take}, 64'd1);
      tick();
      check("t2_inh", {63'd0, in_handler}, 64'd1);
      check("t2_cnt1", {32'd0, exc_count[63:32]}, 64'd2);
      check("t2_cause", {60'd0, cause}, 64'd1);
      do_eret(32'h40);

      // Priority.
      pc_in = 32'h100;
      base = take_cnt;
      push_exp(32'h80, 32'h100, 4'd0);
      push_exp(32'hA0, 32'h100, 4'd2);
      exp_src = 3'b101;
      tick();
      exp_src = 3'b000;
      wait_take(3);
      tick();
      do_eret(32'h100);
      wait_take(3);
      tick();
      do_eret(32'h100);
      tick(); tick();
      check("t3_two_takes", 64'(take_cnt - base), 64'd2);

      // Masking and stall.
      pc_in = 32'h180;
      mask_we = 1'b1; mask_wdata = 3'b110;
      tick();
      mask_we = 1'b0;
      check("t4_mask", {61'd0, mask}, 64'd6);
      base = take_cnt;
      exp_src = 3'b001;
      tick();
      exp_src = 3'b000;
      check("t4_pend0", {61'd0, pending}, 64'd1);
      repeat (5) tick();
      check("t4_masked_no_take", 64'(take_cnt - base), 64'd0);
      cpu_stall = 1'b1;
      mask_we = 1'b1; mask_wdata = 3'b111;
      tick();
      mask_we = 1'b0;
      tick(); tick();
      check("t4_stall_no_take", 64'(take_cnt - base), 64'd0);
      push_exp(32'h80, 32'h180, 4'd0);
      cpu_stall = 1'b0;
      wait_take(3);
      tick();
      do_eret(32'h180);

      // Stray eret, events latched during service.
      pc_in = 32'h200;
      eret = 1'b1;
      tick();
      eret = 1'b0;
      check("t5_stray_ret", {63'd0, ret_take}, 64'd0);
      tick();
      check("t5_stray_inh", {63'd0, in_handler}, 64'd0);
      push_exp(32'hA0, 32'h200, 4'd2);
      exp_src = 3'b100;
      tick();
      exp_src = 3'b000;
      wait_take(3);
      tick();
      base = take_cnt;
      exp_src = 3'b010;
      tick();
      exp_src = 3'b000;
      tick(); tick();
      check("t5_pend1", {61'd0, pending}, 64'd2);
      check("t5_in_service", {63'd0, in_handler}, 64'd1);
      check("t5_no_nest", 64'(take_cnt - base), 64'd0);
      push_exp(32'h90, 32'h200, 4'd1);
      do_eret(32'h200);
      wait_take(3);
      tick();
      do_eret(32'h200);

      // Async reset mid-service; level source retriggers.
      pc_in = 32'h300;
      lvl_src = 3'b001;
      push_exp(32'h80, 32'h300, 4'd0);
      exp_src = 3'b001;
      tick();
      exp_src = 3'b000;
      wait_take(3);
      tick();
      exp_src = 3'b010;
      tick();
      exp_src = 3'b000;
      check("t6_pre_inh", {63'd0, in_handler}, 64'd1);
      check("t6_lvl_inh", {63'd0, lvl_inh}, 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_inh", {63'd0, in_handler}, 64'd0);
      check("t6_async_pend", {61'd0, pending}, 64'd0);
      check("t6_async_cnt", exc_count[63:0], 64'd0);
      check("t6_async_cnt2", {32'd0, exc_count[95:64]}, 64'd0);
      check("t6_async_mask", {61'd0, mask}, 64'd7);
      check("t6_lvl_async_inh", {63'd0, lvl_inh}, 64'd0);
      tick();
      rst = 1'b1;
      begin
         int n = 0;
         while (!lvl_take && n < 4) begin
            tick();
            n++;
         end
      end
      check("t6_lvl_retrigger", {63'd0, lvl_take}, 64'd1);
      check("t6_lvl_vec", {32'd0, lvl_vec}, 64'h80);
      check("t6_lvl_epc", {32'd0, lvl_epc}, 64'h300);
      lvl_src = 3'b000;
      tick(); tick();
      check("t6_main_idle", {63'd0, in_handler}, 64'd0);

      check("sb_exp_empty", 64'(exp_q.size()), 64'd0);
      check("sb_ret_empty", 64'(ret_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
